// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared FSM state encoding and counter width helper for div_restoring
package div_pkg;

    // Controller states: accept operands, iterate one quotient bit per cycle, report.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Iteration counter width; must be able to hold the value W itself.
    function automatic int cw_of(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration (shift in a dividend bit, trial subtract)
module div_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] rem,
    input  logic         dividend_msb,
    input  logic [W-1:0] b,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);

    logic [W-1:0] shifted;
    logic [W:0]   diff;
    logic         unused_rem_msb;

    // The partial remainder before a shift only ever holds the top k<W dividend bits
    // reduced mod b, so its MSB is always zero and can be dropped by the shift.
    assign unused_rem_msb = rem[W-1];
    assign shifted        = {rem[W-2:0], dividend_msb};

    // W+1-bit subtract: the borrow out of bit W tells whether shifted < b.
    assign diff     = {1'b0, shifted} - {1'b0, b};
    assign q_bit    = ~diff[W];
    assign rem_next = q_bit ? diff[W-1:0] : shifted;

endmodule

// File: rtl/div_restoring.sv
// rtl/div_restoring.sv - sequential restoring divider, one quotient bit per clock; optional signed mode via DIV_SIGNED_EN
module div_restoring
    import div_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
`ifdef DIV_SIGNED_EN
    input  logic         signed_mode,
`endif
    output logic         ready,
    output logic         done,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
`ifdef DIV_SIGNED_EN
    output logic         ovf,
`endif
    output logic         dz
);

    localparam int CW = cw_of(W);

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    dvd_q;      // dividend shifting out MSB-first, quotient bits shifting in
    logic [W-1:0]    rem_q;      // partial remainder
    logic [W-1:0]    b_q;        // divisor (magnitude in signed mode)
    logic            ready_q;
    logic            done_q;
    logic [W-1:0]    q_q;
    logic [W-1:0]    r_q;
    logic            dz_q;

    logic [W-1:0]    a_mag_d;
    logic [W-1:0]    b_mag_d;
    logic [W-1:0]    rem_next_d;
    logic            q_bit_d;
    logic [W-1:0]    quo_fin_d;
    logic [W-1:0]    q_res_d;
    logic [W-1:0]    r_res_d;

`ifdef DIV_SIGNED_EN
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic            ovf_pend_q;
    logic            ovf_q;
    logic            a_neg_d;
    logic            b_neg_d;
    logic            ovf_det_d;

    // Operand magnitudes and the most-negative / -1 overflow case, evaluated at acceptance.
    always_comb begin
        a_neg_d   = signed_mode & a[W-1];
        b_neg_d   = signed_mode & b[W-1];
        a_mag_d   = a_neg_d ? (~a + 1'b1) : a;
        b_mag_d   = b_neg_d ? (~b + 1'b1) : b;
        ovf_det_d = signed_mode && (a == {1'b1, {(W-1){1'b0}}}) && (b == {W{1'b1}});
    end
`else
    // Unsigned only: operands are used as-is.
    always_comb begin
        a_mag_d = a;
        b_mag_d = b;
    end
`endif

    div_step #(.W(W)) u_step (
        .rem          (rem_q),
        .dividend_msb (dvd_q[W-1]),
        .b            (b_q),
        .rem_next     (rem_next_d),
        .q_bit        (q_bit_d)
    );

    // Result of the final iteration, with the sign fix-up folded into the same cycle.
    always_comb begin
        quo_fin_d = {dvd_q[W-2:0], q_bit_d};
`ifdef DIV_SIGNED_EN
        q_res_d   = neg_quo_q ? (~quo_fin_d + 1'b1) : quo_fin_d;
        r_res_d   = neg_rem_q ? (~rem_next_d + 1'b1) : rem_next_d;
`else
        q_res_d   = quo_fin_d;
        r_res_d   = rem_next_d;
`endif
    end

    // Controller FSM with datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            b_q     <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        dvd_q   <= a_mag_d;
                        b_q     <= b_mag_d;
                        rem_q   <= '0;
                        cnt_q   <= CW'(W);
                        ready_q <= 1'b0;
`ifdef DIV_SIGNED_EN
                        neg_quo_q  <= a_neg_d ^ b_neg_d;
                        neg_rem_q  <= a_neg_d;
                        ovf_pend_q <= ovf_det_d;
                        ovf_q      <= 1'b0;
`endif
                        if (b == '0) begin
                            // Divide-by-zero short-circuits straight to the report state.
                            q_q     <= '1;
                            r_q     <= a;
                            dz_q    <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            dz_q    <= 1'b0;
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    rem_q <= rem_next_d;
                    dvd_q <= quo_fin_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        q_q     <= q_res_d;
                        r_q     <= r_res_d;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
`ifdef DIV_SIGNED_EN
                        ovf_q   <= ovf_pend_q;
`endif
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign q     = q_q;
    assign r     = r_q;
    assign dz    = dz_q;
`ifdef DIV_SIGNED_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_div_restoring.sv
// tb/tb_div_restoring.sv - randomized self-checking bench for div_restoring (W=8 and W=16 instances)
module tb_div_restoring;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        sm8 = 1'b0;
    logic        ready8, done8, dz8;
    logic [7:0]  q8, r8;
    logic        ovf8;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        sm16 = 1'b0;
    logic        ready16, done16, dz16;
    logic [15:0] q16, r16;
    logic        ovf16;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_restoring #(.W(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
`ifdef DIV_SIGNED_EN
        .signed_mode(sm8), .ovf(ovf8),
`endif
        .ready(ready8), .done(done8), .q(q8), .r(r8), .dz(dz8)
    );

    div_restoring #(.W(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .a(a16), .b(b16),
`ifdef DIV_SIGNED_EN
        .signed_mode(sm16), .ovf(ovf16),
`endif
        .ready(ready16), .done(done16), .q(q16), .r(r16), .dz(dz16)
    );

`ifndef DIV_SIGNED_EN
    assign ovf8  = 1'b0;
    assign ovf16 = 1'b0;
`endif

    // Reference: plain arithmetic on the operands, truncating signed division when enabled.
    function automatic void model8(input logic [7:0] av, input logic [7:0] bv, input bit sm,
                                   output logic [7:0] eq, output logic [7:0] er,
                                   output logic edz, output logic eovf, output int elat);
        int sa, sb;
        eovf = 1'b0;
        edz  = 1'b0;
        elat = 9;
        if (bv == 8'd0) begin
            eq = 8'hFF; er = av; edz = 1'b1; elat = 1;
        end else if (sm) begin
            sa = $signed(av);
            sb = $signed(bv);
            if (sa == -128 && sb == -1) begin
                eq = 8'h80; er = 8'h00; eovf = 1'b1;
            end else begin
                eq = 8'(sa / sb);
                er = 8'(sa % sb);
            end
        end else begin
            eq = av / bv;
            er = av % bv;
        end
    endfunction

    // Issue one start pulse on the W=8 instance and wait for done; lat counts cycles after the accepting edge.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input bit sm,
                       output int lat, output logic [7:0] qo, output logic [7:0] ro,
                       output logic dzo, output logic ovfo, output logic rdy_after, output logic done_after);
        @(negedge clk);
        a8 = av; b8 = bv; sm8 = sm; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        qo = q8; ro = r8; dzo = dz8; ovfo = ovf8;
        @(posedge clk); #1;
        rdy_after = ready8;
        done_after = done8;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start8 = 1'b1; a8 = 8'd100; b8 = 8'd7;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ready8, done8, q8, r8, dz8, ovf8} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: got ready=%0b done=%0b q=%0h r=%0h dz=%0b ovf=%0b, want 1 0 0 0 0 0",
                     ready8, done8, q8, r8, dz8, ovf8);
        end
        checks++;
        if (ready16 !== 1'b1 || q16 !== 16'h0) begin
            failures++;
            $display("FAIL reset_state16: got ready=%0b q=%0h, want 1 0", ready16, q16);
        end
        @(negedge clk);
        start8 = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int lat; logic [7:0] qo, ro; logic dzo, ovfo, rdy, dn;
        op8(8'd100, 8'd7, 1'b0, lat, qo, ro, dzo, ovfo, rdy, dn);
        checks++;
        if (lat !== 9) begin failures++; $display("FAIL basic_latency: got %0d, want 9", lat); end
        checks++;
        if (qo !== 8'd14 || ro !== 8'd2 || dzo !== 1'b0) begin
            failures++; $display("FAIL basic_result: got q=%0d r=%0d dz=%0b, want 14 2 0", qo, ro, dzo);
        end
        checks++;
        if (rdy !== 1'b1 || dn !== 1'b0) begin
            failures++; $display("FAIL basic_after: got ready=%0b done=%0b, want 1 0", rdy, dn);
        end
    endtask

    task automatic test_div_by_zero();
        int lat; logic [7:0] qo, ro; logic dzo, ovfo, rdy, dn;
        op8(8'd5, 8'd0, 1'b0, lat, qo, ro, dzo, ovfo, rdy, dn);
        checks++;
        if (lat !== 1) begin failures++; $display("FAIL dz_latency: got %0d, want 1", lat); end
        checks++;
        if (qo !== 8'hFF || ro !== 8'd5 || dzo !== 1'b1) begin
            failures++; $display("FAIL dz_result: got q=%0h r=%0d dz=%0b, want ff 5 1", qo, ro, dzo);
        end
    endtask

    task automatic test_edges();
        int lat; logic [7:0] qo, ro; logic dzo, ovfo, rdy, dn;
        op8(8'd255, 8'd1, 1'b0, lat, qo, ro, dzo, ovfo, rdy, dn);
        checks++;
        if (qo !== 8'd255 || ro !== 8'd0 || dzo !== 1'b0) begin
            failures++; $display("FAIL edge_255_1: got q=%0d r=%0d dz=%0b, want 255 0 0", qo, ro, dzo);
        end
        op8(8'd3, 8'd200, 1'b0, lat, qo, ro, dzo, ovfo, rdy, dn);
        checks++;
        if (qo !== 8'd0 || ro !== 8'd3) begin
            failures++; $display("FAIL edge_3_200: got q=%0d r=%0d, want 0 3", qo, ro);
        end
    endtask

    task automatic test_ignore_start();
        int cyc; bit early;
        @(negedge clk);
        a8 = 8'd100; b8 = 8'd7; sm8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        cyc = 1; early = 0;
        checks++;
        if (ready8 !== 1'b0) begin failures++; $display("FAIL busy_ready: got %0b, want 0", ready8); end
        while (!done8 && cyc < 40) begin
            if (cyc == 4) begin a8 = 8'd9; b8 = 8'd1; start8 = 1'b1; end
            if (cyc == 5) start8 = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== 9 || q8 !== 8'd14 || r8 !== 8'd2) begin
            failures++; $display("FAIL ignore_start: got cycle=%0d q=%0d r=%0d, want 9 14 2", cyc, q8, r8);
        end
        repeat (4) begin
            @(posedge clk); #1;
            if (done8) early = 1;
        end
        checks++;
        if (early !== 1'b0 || ready8 !== 1'b1) begin
            failures++; $display("FAIL no_queueing: got extra_done=%0b ready=%0b, want 0 1", early, ready8);
        end
    endtask

    task automatic test_reset_abort();
        int cyc; bit seen;
        @(negedge clk);
        a8 = 8'd100; b8 = 8'd7; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        cyc = 1; seen = 0;
        while (cyc < 5) begin
            if (done8) seen = 1;
            @(posedge clk); #1;
            cyc++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        if (done8) seen = 1;
        checks++;
        if ({ready8, q8, r8, dz8, ovf8} !== {1'b1, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            failures++; $display("FAIL abort_outputs: got ready=%0b q=%0h r=%0h dz=%0b, want 1 0 0 0", ready8, q8, r8, dz8);
        end
        repeat (10) begin
            @(posedge clk); #1;
            if (done8) seen = 1;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL abort_done: got done pulse=%0b, want 0", seen); end
    endtask

    task automatic test_back_to_back();
        int cyc, first, second; logic [7:0] fq, fr, sq, sr;
        @(negedge clk);
        a8 = 8'd100; b8 = 8'd7; sm8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1 a8 = 8'd200; b8 = 8'd9;
        cyc = 1; first = 0; second = 0; fq = '0; fr = '0; sq = '0; sr = '0;
        while (cyc < 40 && second == 0) begin
            if (done8) begin
                if (first == 0) begin first = cyc; fq = q8; fr = r8; end
                else begin second = cyc; sq = q8; sr = r8; end
            end
            if (second == 0) begin @(posedge clk); #1; cyc++; end
        end
        start8 = 1'b0;
        checks++;
        if (first !== 9 || fq !== 8'd14 || fr !== 8'd2) begin
            failures++; $display("FAIL b2b_first: got cycle=%0d q=%0d r=%0d, want 9 14 2", first, fq, fr);
        end
        checks++;
        if (second !== 19 || sq !== 8'd22 || sr !== 8'd2) begin
            failures++; $display("FAIL b2b_second: got cycle=%0d q=%0d r=%0d, want 19 22 2", second, sq, sr);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_random(input bit sm, input int n);
        int lat, elat; logic [7:0] av, bv, qo, ro, eq, er; logic dzo, ovfo, edz, eovf, rdy, dn;
        for (int i = 0; i < n; i++) begin
            av = 8'($urandom);
            bv = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            if (i == 0) begin av = 8'h80; bv = 8'hFF; end
            op8(av, bv, sm, lat, qo, ro, dzo, ovfo, rdy, dn);
            model8(av, bv, sm, eq, er, edz, eovf, elat);
            checks++;
            if (lat !== elat) begin
                failures++; $display("FAIL rand_latency a=%0h b=%0h sm=%0b: got %0d, want %0d", av, bv, sm, lat, elat);
            end
            checks++;
            if (qo !== eq || ro !== er) begin
                failures++; $display("FAIL rand_result a=%0h b=%0h sm=%0b: got q=%0h r=%0h, want q=%0h r=%0h", av, bv, sm, qo, ro, eq, er);
            end
            checks++;
            if (dzo !== edz || ovfo !== eovf) begin
                failures++; $display("FAIL rand_flags a=%0h b=%0h sm=%0b: got dz=%0b ovf=%0b, want %0b %0b", av, bv, sm, dzo, ovfo, edz, eovf);
            end
        end
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed();
        int lat; logic [7:0] qo, ro; logic dzo, ovfo, rdy, dn;
        op8(8'hF9, 8'd2, 1'b1, lat, qo, ro, dzo, ovfo, rdy, dn);
        checks++;
        if (qo !== 8'hFD || ro !== 8'hFF || ovfo !== 1'b0 || lat !== 9) begin
            failures++; $display("FAIL signed_m7_2: got q=%0h r=%0h ovf=%0b lat=%0d, want fd ff 0 9", qo, ro, ovfo, lat);
        end
        op8(8'h80, 8'hFF, 1'b1, lat, qo, ro, dzo, ovfo, rdy, dn);
        checks++;
        if (qo !== 8'h80 || ro !== 8'h00 || ovfo !== 1'b1 || lat !== 9) begin
            failures++; $display("FAIL signed_ovf: got q=%0h r=%0h ovf=%0b lat=%0d, want 80 0 1 9", qo, ro, ovfo, lat);
        end
        op8(8'hF9, 8'h00, 1'b1, lat, qo, ro, dzo, ovfo, rdy, dn);
        checks++;
        if (qo !== 8'hFF || ro !== 8'hF9 || dzo !== 1'b1) begin
            failures++; $display("FAIL signed_dz: got q=%0h r=%0h dz=%0b, want ff f9 1", qo, ro, dzo);
        end
        test_random(1'b1, 30);
    endtask
`endif

    task automatic test_w16();
        int cyc;
        @(negedge clk);
        a16 = 16'd100; b16 = 16'd7; sm16 = 1'b0; start16 = 1'b1;
        @(posedge clk);
        #1 start16 = 1'b0;
        cyc = 1;
        while (!done16 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== 17 || q16 !== 16'd14 || r16 !== 16'd2 || dz16 !== 1'b0) begin
            failures++; $display("FAIL w16_basic: got cycle=%0d q=%0d r=%0d dz=%0b, want 17 14 2 0", cyc, q16, r16, dz16);
        end
        @(posedge clk); #1;
        checks++;
        if (ready16 !== 1'b1 || done16 !== 1'b0) begin
            failures++; $display("FAIL w16_after: got ready=%0b done=%0b, want 1 0", ready16, done16);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_by_zero();
        test_edges();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_random(1'b0, 40);
`ifdef DIV_SIGNED_EN
        test_signed();
`endif
        test_w16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
